// File: rtl/dac_player_pkg.sv
`default_nettype none
//==============================================================================
// dac_player_pkg : state encoding, pipe width and depth helper for the player
// Rev 1.0
//==============================================================================
package dac_player_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   localparam int PIPE_WIDTH = 16;

   function automatic int depth_of(input int depth_log2);
      return 1 << depth_log2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dac_pattern_player_if.sv
`default_nettype none
//==============================================================================
// dac_pattern_player_if : pipe-in write port and DAC output port of the player
// Rev 1.0
//==============================================================================
interface dac_pattern_player_if
   import dac_player_pkg::*;
#(
   parameter int PRECISION = 10
);
   logic                  pipe_wr;
   logic [PIPE_WIDTH-1:0] pipe_din;
   logic [PRECISION-1:0]  dac_code;
   logic                  dac_strobe;

   modport master (
      output pipe_wr,
      output pipe_din,
      input  dac_code,
      input  dac_strobe
   );

   modport slave (
      input  pipe_wr,
      input  pipe_din,
      output dac_code,
      output dac_strobe
   );
endinterface
`default_nettype wire

// File: rtl/pattern_ram.sv
`default_nettype none
//==============================================================================
// pattern_ram : simple dual-port RAM, synchronous write, registered read
// Rev 1.0
//==============================================================================
module pattern_ram
   import dac_player_pkg::*;
#(
   parameter int PRECISION  = 10,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [PRECISION-1:0]  wdata,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [PRECISION-1:0]  rdata
);
   localparam int DEPTH = depth_of(DEPTH_LOG2);

   logic [PRECISION-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register only advances on re, so it doubles as the held DAC code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end
endmodule
`default_nettype wire

// File: rtl/dac_pattern_player.sv
`default_nettype none
//==============================================================================
// dac_pattern_player : buffers pipe-in words and plays them as DAC codes
// (stream or loop); optional test ramp under PATTERN_RAMP_EN.   Rev 1.0
//==============================================================================
module dac_pattern_player
   import dac_player_pkg::*;
#(
   parameter int PRECISION  = 10,
   parameter int DEPTH_LOG2 = 10,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   dac_pattern_player_if.slave  bus,
   input  logic                 clear,
   input  logic                 play_en,
   input  logic                 loop_en,
   input  logic [DIV_WIDTH-1:0] rate_div,
   input  logic                 test_ramp,
   output logic [DEPTH_LOG2:0]  word_count,
   output logic                 full,
   output logic                 underrun,
   output logic                 overflow,
   output logic                 playing
);
   localparam int            CW         = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(depth_of(DEPTH_LOG2));

   state_t                state;
   logic                  loop_mode;
   logic [DIV_WIDTH-1:0]  div_cnt;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] rd_addr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         offset;
   logic                  strobe_q;
   logic [PRECISION-1:0]  ram_q;

   logic in_play, has_data, tick, ramp_sel, start;
   logic wr_ok, wr_drop, stream_tick, loop_tick, pop, ram_re;

   assign in_play     = (state == ST_PLAY);
   assign has_data    = (count != '0);
   assign full        = (count == FULL_COUNT);
   assign tick        = in_play && play_en && !clear && (div_cnt == rate_div);
   assign stream_tick = tick && !ramp_sel && !loop_mode;
   assign loop_tick   = tick && !ramp_sel && loop_mode && has_data;
   assign pop         = stream_tick && has_data;
   assign ram_re      = pop || loop_tick;
   assign wr_ok       = bus.pipe_wr && !clear && !full && !(in_play && loop_mode);
   assign wr_drop     = bus.pipe_wr && !clear && !wr_ok;
   assign start       = !in_play && play_en && !clear && (has_data || ramp_sel);
   assign rd_addr     = loop_mode ? (rd_ptr + offset[DEPTH_LOG2-1:0]) : rd_ptr;

   assign word_count     = count;
   assign playing        = in_play;
   assign bus.dac_strobe = strobe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         loop_mode <= 1'b0;
         div_cnt   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         offset    <= '0;
         strobe_q  <= 1'b0;
         underrun  <= 1'b0;
         overflow  <= 1'b0;
      end else if (clear) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         offset   <= '0;
         strobe_q <= 1'b0;
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (wr_drop) begin
            overflow <= 1'b1;
         end
         case ({wr_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         case (state)
            ST_IDLE: begin
               offset <= '0;
               if (start) begin
                  state     <= ST_PLAY;
                  loop_mode <= loop_en;
                  // Preload so the very first PLAY cycle is a tick.
                  div_cnt   <= rate_div;
               end
            end
            ST_PLAY: begin
               if (!play_en) begin
                  state  <= ST_IDLE;
                  offset <= '0;
               end else begin
                  div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
                  if (tick) begin
                     if (ramp_sel) begin
                        strobe_q <= 1'b1;
                     end else if (loop_mode) begin
                        if (has_data) begin
                           strobe_q <= 1'b1;
                           offset   <= (offset + CW'(1) == count) ? '0 : offset + CW'(1);
                        end
                     end else if (has_data) begin
                        strobe_q <= 1'b1;
                        rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
                     end else begin
                        underrun <= 1'b1;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   pattern_ram #(
      .PRECISION  (PRECISION),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (bus.pipe_din[PRECISION-1:0]),
      .re    (ram_re),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

`ifdef PATTERN_RAMP_EN
   logic [PRECISION-1:0] ramp_cnt;
   logic [PRECISION-1:0] ramp_out;
   logic                 src_ramp;

   assign ramp_sel = test_ramp;

   // src_ramp remembers which source produced the last code so it holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ramp_cnt <= '0;
         ramp_out <= '0;
         src_ramp <= 1'b0;
      end else begin
         if (!in_play) begin
            ramp_cnt <= '0;
         end
         if (tick && ramp_sel) begin
            ramp_out <= ramp_cnt;
            ramp_cnt <= ramp_cnt + PRECISION'(1);
            src_ramp <= 1'b1;
         end else if (ram_re) begin
            src_ramp <= 1'b0;
         end
      end
   end

   assign bus.dac_code = src_ramp ? ramp_out : ram_q;
`else
   logic unused_test_ramp;

   assign ramp_sel         = 1'b0;
   assign unused_test_ramp = test_ramp;
   assign bus.dac_code     = ram_q;
`endif

   logic unused_pipe_bits;
   assign unused_pipe_bits = &{1'b0, bus.pipe_din[PIPE_WIDTH-1:PRECISION]};

endmodule
`default_nettype wire

// File: tb/tb_dac_pattern_player.sv
`default_nettype none
//==============================================================================
// tb_dac_pattern_player : table vectors, directed corner cases and random
// stimulus against a queue-based reference model.   Rev 1.0
//==============================================================================
module tb_dac_pattern_player;
   import dac_player_pkg::*;

   localparam int P     = 10;
   localparam int DL    = 10;
   localparam int DW    = 16;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear, play_en, loop_en, test_ramp;
   logic [DW-1:0] rate_div;
   logic [DL:0]   word_count;
   logic          full, underrun, overflow, playing;

   dac_pattern_player_if #(.PRECISION(P)) bus ();

   dac_pattern_player #(
      .PRECISION  (P),
      .DEPTH_LOG2 (DL),
      .DIV_WIDTH  (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clear      (clear),
      .play_en    (play_en),
      .loop_en    (loop_en),
      .rate_div   (rate_div),
      .test_ramp  (test_ramp),
      .word_count (word_count),
      .full       (full),
      .underrun   (underrun),
      .overflow   (overflow),
      .playing    (playing)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: buffer as a queue, playback phase as a cycle count.
   logic [P-1:0] mq[$];
   bit           m_play, m_loop, m_strobe, m_under, m_over;
   int           m_k, m_off, m_ramp;
   logic [P-1:0] m_code;

   typedef struct {
      bit          wr;
      logic [15:0] din;
      bit          pe;
      logic [15:0] rd;
      logic [P-1:0] code;
      bit          strobe;
      int          count;
      bit          under;
      bit          play;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      mq.delete();
      m_play = 0; m_loop = 0; m_strobe = 0; m_under = 0; m_over = 0;
      m_k = 0; m_off = 0; m_ramp = 0; m_code = '0;
   endfunction

   function automatic void model_edge();
      int sz;
      bit tick, tr;
      if (clear) begin
         mq.delete();
         m_under = 0; m_over = 0; m_play = 0; m_strobe = 0; m_off = 0; m_ramp = 0;
         return;
      end
      sz = mq.size();
`ifdef PATTERN_RAMP_EN
      tr = test_ramp;
`else
      tr = 1'b0;
`endif
      tick = m_play && play_en && ((m_k % (int'(rate_div) + 1)) == 0);
      m_strobe = 0;
      if (tick) begin
         if (tr) begin
            m_code = m_ramp[P-1:0];
            m_ramp = (m_ramp + 1) % (1 << P);
            m_strobe = 1;
         end else if (m_loop) begin
            if (sz > 0) begin
               m_code = mq[m_off];
               m_strobe = 1;
               m_off = (m_off + 1 == sz) ? 0 : m_off + 1;
            end
         end else if (sz > 0) begin
            m_code = mq.pop_front();
            m_strobe = 1;
         end else begin
            m_under = 1;
         end
      end
      if (bus.pipe_wr) begin
         if (sz == DEPTH || (m_play && m_loop)) m_over = 1;
         else mq.push_back(bus.pipe_din[P-1:0]);
      end
      if (!m_play) begin
         m_off = 0;
         m_ramp = 0;
         if (play_en && (sz > 0 || tr)) begin
            m_play = 1; m_loop = loop_en; m_k = 0;
         end
      end else if (!play_en) begin
         m_play = 0; m_off = 0;
      end else begin
         m_k++;
      end
   endfunction

   task automatic compare_all();
      check("dac_code",   bus.dac_code,   m_code);
      check("dac_strobe", bus.dac_strobe, m_strobe);
      check("word_count", word_count,     mq.size());
      check("full",       full,           mq.size() == DEPTH);
      check("underrun",   underrun,       m_under);
      check("overflow",   overflow,       m_over);
      check("playing",    playing,        m_play);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic write_word(input logic [15:0] d);
      bus.pipe_wr = 1'b1; bus.pipe_din = d;
      cycle();
      bus.pipe_wr = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.pipe_wr = 1'b0; play_en = 1'b0; clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   function automatic void add(bit wr, logic [15:0] din, bit pe, logic [15:0] rd,
                               logic [P-1:0] code, bit strobe, int count, bit under, bit play);
      vec_t v;
      v.wr = wr; v.din = din; v.pe = pe; v.rd = rd; v.code = code;
      v.strobe = strobe; v.count = count; v.under = under; v.play = play;
      tbl.push_back(v);
   endfunction

   initial begin
      rst = 1'b1; clear = 1'b0; play_en = 1'b0; loop_en = 1'b0; test_ramp = 1'b0;
      rate_div = '0; bus.pipe_wr = 1'b0; bus.pipe_din = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;

      // Stream, rate_div=3: codes 1,2,3 four cycles apart, then underrun.
      add(1, 16'h001, 0, 3, 0, 0, 1, 0, 0);
      add(1, 16'h002, 0, 3, 0, 0, 2, 0, 0);
      add(1, 16'h003, 0, 3, 0, 0, 3, 0, 0);
      add(0, 16'h000, 1, 3, 0, 0, 3, 0, 1);
      add(0, 16'h000, 1, 3, 1, 1, 2, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 3, 1, 0, 2, 0, 1);
      add(0, 16'h000, 1, 3, 2, 1, 1, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 3, 2, 0, 1, 0, 1);
      add(0, 16'h000, 1, 3, 3, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 3, 3, 0, 0, 0, 1);
      add(0, 16'h000, 1, 3, 3, 0, 0, 1, 1);
      add(0, 16'h000, 0, 3, 3, 0, 0, 1, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         bus.pipe_wr = tbl[i].wr; bus.pipe_din = tbl[i].din;
         play_en = tbl[i].pe; rate_div = tbl[i].rd;
         cycle();
         check("tbl_code",   bus.dac_code,   tbl[i].code);
         check("tbl_strobe", bus.dac_strobe, tbl[i].strobe);
         check("tbl_count",  word_count,     tbl[i].count);
         check("tbl_under",  underrun,       tbl[i].under);
         check("tbl_play",   playing,        tbl[i].play);
      end
      bus.pipe_wr = 1'b0;

      // Loop, rate_div=0: 3FF,000 alternate every cycle; write is dropped.
      pulse_clear();
      rate_div = 0; loop_en = 1'b1;
      write_word(16'h03FF);
      write_word(16'h0000);
      play_en = 1'b1;
      cycle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("loop_code",   bus.dac_code, (i % 2 == 0) ? 32'h3FF : 32'h000);
         check("loop_strobe", bus.dac_strobe, 1);
         check("loop_count",  word_count, 2);
      end
      write_word(16'h0123);
      check("loop_overflow", overflow, 1);
      check("loop_count_wr", word_count, 2);
      play_en = 1'b0;
      cycle();

      // Fill to full, one extra write overflows; then pop with concurrent write.
      pulse_clear();
      loop_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) write_word(16'($urandom));
      write_word(16'h0055);
      check("fill_full",     full, 1);
      check("fill_overflow", overflow, 1);
      check("fill_count",    word_count, DEPTH);
      play_en = 1'b1;
      cycle();
      bus.pipe_wr = 1'b1; bus.pipe_din = 16'h0111;
      cycle();
      check("pop_full_drop", word_count, DEPTH - 1);
      bus.pipe_din = 16'h0222;
      cycle();
      check("pop_and_write", word_count, DEPTH - 1);
      bus.pipe_wr = 1'b0;

      // Asynchronous reset mid-play clears every output at once.
      rst = 1'b1;
      #1;
      check("rst_code",     bus.dac_code, 0);
      check("rst_strobe",   bus.dac_strobe, 0);
      check("rst_count",    word_count, 0);
      check("rst_full",     full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_playing",  playing, 0);
      m_reset();
      play_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();

      // Upper pipe bits are ignored.
      write_word(16'hFC05);
      play_en = 1'b1;
      cycle();
      cycle();
      check("trunc_code",   bus.dac_code, 10'h005);
      check("trunc_strobe", bus.dac_strobe, 1);
      cycle();
      check("trunc_under",  underrun, 1);
      play_en = 1'b0;
      cycle();

      // clear during loop play: back to idle, flags cleared, code held.
      pulse_clear();
      loop_en = 1'b1;
      write_word(16'h0155);
      write_word(16'h02AA);
      play_en = 1'b1;
      cycle();
      cycle();
      write_word(16'h0001);
      cycle();
      check("pre_clr_over", overflow, 1);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      check("clr_playing", playing, 0);
      check("clr_count",   word_count, 0);
      check("clr_over",    overflow, 0);
      check("clr_under",   underrun, 0);
      check("clr_code",    bus.dac_code, 10'h155);
      play_en = 1'b0;
      cycle();

`ifdef PATTERN_RAMP_EN
      // Ramp with empty buffer: 0,1,2,... wrapping 3FF -> 000, never underruns.
      pulse_clear();
      test_ramp = 1'b1; rate_div = 0; loop_en = 1'b0; play_en = 1'b1;
      cycle();
      for (int i = 0; i < DEPTH + 6; i++) begin
         cycle();
         check("ramp_code",  bus.dac_code, i % DEPTH);
         check("ramp_under", underrun, 0);
      end
      play_en = 1'b0;
      cycle();
      test_ramp = 1'b0;
`endif

      // Randomized traffic; rate_div only changes while idle with play_en low.
      pulse_clear();
      for (int n = 0; n < 4000; n++) begin
         bus.pipe_wr  = ($urandom_range(0, 99) < 40);
         bus.pipe_din = 16'($urandom);
         clear        = ($urandom_range(0, 499) == 0);
         loop_en      = 1'($urandom);
         if ($urandom_range(0, 29) == 0) play_en = ~play_en;
         if (!m_play && !play_en) rate_div = 16'($urandom_range(0, 3));
`ifdef PATTERN_RAMP_EN
         if ($urandom_range(0, 99) == 0) test_ramp = ~test_ramp;
`endif
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
